// File: rtl/pwe_pkg.sv
// Shared definitions for the pulse-width engine scheduler: FSM state
// encodings, parameter defaults and an index-width helper.
package pwe_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WBITS_DEF = 4;
    localparam int GAP_DEF   = 1;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_PULSE = 2'd1;
    localparam logic [1:0] ENC_DONE  = 2'd2;
    localparam logic [1:0] ENC_GAP   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_PULSE = ENC_PULSE,
        ST_DONE  = ENC_DONE,
        ST_GAP   = ENC_GAP
    } state_t;

    // Bits needed to index n items; never less than one so ports stay legal.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwe_rr_arb.sv
// Rotating-priority selector: the search starts at ptr and the first asserted
// request wins. A constant zero ptr gives plain lowest-index priority.
module pwe_rr_arb
    import pwe_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = idx_bits(NREQ_DEF)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   idx
);

    always_comb begin
        logic found;
        int   j;
        win   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                win[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/pwe_sched.sv
// Shares one pulse engine among NREQ requesters, one pulse at a time.
// Define PWE_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
//
// state    | meaning
// IDLE     | no owner; grants on the first edge with ena and a request
// PULSE    | pulse_out high for the latched width, counter runs down
// DONE     | one-cycle done strobe to the owner, grant still held
// GAP      | forced idle spacing before the next grant
module pwe_sched
    import pwe_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WBITS = WBITS_DEF,
    parameter int GAP   = GAP_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WBITS-1:0] width_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  pulse_out,
    output logic [NREQ-1:0]       done,
    output logic                  busy
);

    localparam int IW = idx_bits(NREQ);
    localparam int GW = idx_bits(GAP + 1);
    localparam int CW = (WBITS > GW) ? WBITS : GW;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            pulse_q, pulse_d;
    logic            busy_q, busy_d;

    logic [IW-1:0]   arb_ptr;
    logic [NREQ-1:0] arb_win;
    logic [IW-1:0]   arb_idx;
    logic [WBITS-1:0] w_sel;

`ifdef PWE_SCHED_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [IW-1:0] ptr_q, ptr_d;
    assign arb_ptr = ptr_q;
`endif

    pwe_rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req  (req),
        .ptr  (arb_ptr),
        .win  (arb_win),
        .idx  (arb_idx)
    );

    assign w_sel = width_in[int'(arb_idx)*WBITS +: WBITS];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
`ifndef PWE_SCHED_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ena && |arb_win) begin
                    idx_d = arb_idx;
`ifndef PWE_SCHED_FIXED_PRIO_EN
                    ptr_d = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
`endif
                    if (w_sel != '0) begin
                        state_d = ST_PULSE;
                        cnt_d   = CW'(w_sel);
                    end else begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_PULSE: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (GAP > 0) begin
                    state_d = ST_GAP;
                    cnt_d   = CW'(GAP);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs follow the next state so they are flops, never input-driven.
        gnt_d   = (state_d == ST_PULSE || state_d == ST_DONE) ? (NREQ'(1) << idx_d) : '0;
        done_d  = (state_d == ST_DONE) ? (NREQ'(1) << idx_d) : '0;
        pulse_d = (state_d == ST_PULSE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
`ifndef PWE_SCHED_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
`ifndef PWE_SCHED_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign pulse_out = pulse_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pwe_sched.sv
// Directed bench for pwe_sched with default parameters (NREQ=4, WBITS=4, GAP=1);
// expected grant indices switch with PWE_SCHED_FIXED_PRIO_EN.
module tb_pwe_sched;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [3:0]  req;
    logic [15:0] width_in;
    logic [3:0]  gnt;
    logic        pulse_out;
    logic [3:0]  done;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    pwe_sched #(.NREQ(4), .WBITS(4), .GAP(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .req       (req),
        .width_in  (width_in),
        .gnt       (gnt),
        .pulse_out (pulse_out),
        .done      (done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] win;
        int          idx_rr;
        int          idx_fp;
    } vec_t;

    // Observed outputs packed as {gnt, pulse_out, done, busy}.
    function automatic logic [9:0] pack_exp(input logic [3:0] g, input logic p,
                                            input logic [3:0] d, input logic b);
        return {g, p, d, b};
    endfunction

    task automatic chk(input string name, input logic [9:0] exp);
        logic [9:0] act;
        act = {gnt, pulse_out, done, busy};
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got gnt/pulse/done/busy=%b expected %b", name, act, exp);
    endtask

    // Called #1 after the grant edge; walks pulse, done, gap and the idle cycle.
    task automatic check_txn(input string tag, input int idx, input int w);
        logic [3:0] oh;
        logic [9:0] exp;
        oh = 4'b0001 << idx;
        for (int c = 0; c <= w + 2; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (c < w)           exp = pack_exp(oh, 1'b1, 4'b0000, 1'b1);
            else if (c == w)     exp = pack_exp(oh, 1'b0, oh, 1'b1);
            else if (c == w + 1) exp = pack_exp(4'b0000, 1'b0, 4'b0000, 1'b1);
            else                 exp = pack_exp(4'b0000, 1'b0, 4'b0000, 1'b0);
            chk($sformatf("%s_c%0d", tag, c), exp);
        end
    endtask

    vec_t vecs[6];
    int   order[5];

    initial begin
        int idx;
        int w;

        vecs[0] = '{req: 4'b0001, win: 16'h0003, idx_rr: 0, idx_fp: 0};
        vecs[1] = '{req: 4'b0100, win: 16'h0000, idx_rr: 2, idx_fp: 2};
        vecs[2] = '{req: 4'b0011, win: 16'h0015, idx_rr: 0, idx_fp: 0};
        vecs[3] = '{req: 4'b1010, win: 16'h20F0, idx_rr: 1, idx_fp: 1};
        vecs[4] = '{req: 4'b1001, win: 16'h7004, idx_rr: 3, idx_fp: 0};
        vecs[5] = '{req: 4'b1111, win: 16'h4321, idx_rr: 0, idx_fp: 0};

        rst_n    = 1'b0;
        ena      = 1'b1;
        req      = '0;
        width_in = '0;
        #23;
        chk("reset_state", 10'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
`ifdef PWE_SCHED_FIXED_PRIO_EN
            idx = vecs[v].idx_fp;
`else
            idx = vecs[v].idx_rr;
`endif
            w = int'((vecs[v].win >> (idx * 4)) & 16'h000F);
            @(negedge clk);
            req      = vecs[v].req;
            width_in = vecs[v].win;
            @(posedge clk);
            #1;
            // Withdrawing req and scrambling widths must not disturb the pulse.
            req      = '0;
            width_in = 16'hFFFF;
            check_txn($sformatf("vec%0d", v), idx, w);
        end

        // Reset in the third cycle of a width-15 pulse.
        @(negedge clk);
        req      = 4'b0100;
        width_in = 16'h0F00;
        @(posedge clk);
        #1;
        req = '0;
        chk("rst_pulse_c0", pack_exp(4'b0100, 1'b1, 4'b0000, 1'b1));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_pulse_c2", pack_exp(4'b0100, 1'b1, 4'b0000, 1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_clear", 10'b0);
        req      = 4'b1111;
        width_in = 16'h2222;
        @(negedge clk);
        rst_n = 1'b1;

        // All requesters held: pointer restarts at 0 after reset.
`ifdef PWE_SCHED_FIXED_PRIO_EN
        order = '{0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        for (int r = 0; r < 5; r++) begin
            @(posedge clk);
            #1;
            check_txn($sformatf("rr%0d", r), order[r], 2);
        end
        req = '0;

        // ena gating: no grant while low, in-flight pulse finishes after dropping it.
        @(negedge clk);
        ena      = 1'b0;
        req      = 4'b0010;
        width_in = 16'h0030;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("ena_off_%0d", k), 10'b0);
        end
        @(negedge clk);
        ena = 1'b1;
        @(posedge clk);
        #1;
        ena = 1'b0;
        check_txn("ena_mid", 1, 3);
        @(posedge clk);
        #1;
        chk("ena_off_after", 10'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pwe_sched.md
PWE_SCHED -- requirements
Module: pwe_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the pulse engine.
REQ-002 SHALL have parameter WBITS, default 4, pulse-width field width per requester.
REQ-003 SHALL have parameter GAP, default 1, idle cycles forced between consecutive pulses (0 allowed).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ena  input  1  scheduler enable; gates new grants only.
REQ-007 SHALL have port req  input  NREQ  level request per requester, held until its done.
REQ-008 SHALL have port width_in  input  NREQ*WBITS  requester i width at bits [i*WBITS +: WBITS].
REQ-009 SHALL have port gnt  output  NREQ  one-hot grant, zero when no pulse is owned.
REQ-010 SHALL have port pulse_out  output  1  shared pulse, high exactly W cycles.
REQ-011 SHALL have port done  output  NREQ  one-cycle completion strobe to the owning requester.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, PULSE, DONE, GAP; all outputs decoded from registered state/index only, no combinational input-to-output path.
REQ-014 IDLE: when ena=1 and req!=0 at an edge, SHALL latch winner index and its width W; next state PULSE if W>0, else DONE.
REQ-015 PULSE: pulse_out=1, gnt[idx]=1; down-counter loaded with W, decremented each cycle; leaves to DONE after exactly W cycles.
REQ-016 DONE: one cycle, done[idx]=1, gnt[idx]=1, pulse_out=0; next GAP if GAP>0, else IDLE.
REQ-017 GAP: all outputs low except busy; exactly GAP cycles, then IDLE.
REQ-018 Latency: req sampled in IDLE at edge k SHALL give gnt and pulse_out high from edge k, i.e. visible in cycle k+1.
REQ-019 Arbitration SHALL be round-robin: search starts at pointer, first asserted req wins; pointer becomes (winner+1) mod NREQ at grant.
REQ-020 Withdrawal of req[idx] after grant SHALL NOT abort or shorten the pulse; width_in changes after latch SHALL be ignored.
REQ-021 ena deasserted mid-operation SHALL let the current pulse, done and gap finish; no new grant while ena=0.
REQ-022 W = 2^WBITS-1 (15) SHALL give 15 pulse cycles; counter SHALL never wrap.
REQ-023 A requester still asserting req in DONE SHALL be treated as a new request at the next IDLE.

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE, pointer 0, counter 0, gnt 0, done 0, pulse_out 0, busy 0, including mid-pulse.
REQ-025 After rst_n rises, first grant SHALL be possible at the first clock edge.

Configuration
REQ-026 Macro PWE_SCHED_FIXED_PRIO_EN defined: fixed priority, lowest index wins, pointer logic removed.
REQ-027 Macro PWE_SCHED_FIXED_PRIO_EN undefined (default): round-robin per REQ-019.

Structure
REQ-028 Shared package pwe_pkg SHALL hold the state enum, NREQ/WBITS defaults and state encodings.
REQ-029 Round-robin/priority selection SHALL be sub-module pwe_rr_arb (req, pointer in; one-hot winner, index out).

Verification
REQ-030 req=0001, width0=3, GAP=1 -> pulse_out high 3 cycles, done[0] 1 cycle after, busy low 1 cycle later.
REQ-031 req=1111 held, all widths 2 -> grant order 0,1,2,3,0; each pulse 2 cycles, gap 1.
REQ-032 req=0100, width2=0 -> no pulse_out, done[2] one cycle after sampling edge.
REQ-033 rst_n low during 3rd cycle of width-15 pulse -> all outputs 0 immediately, next grant restarts at pointer 0.
REQ-034 ena=0 with req=0010 -> no gnt; ena=1 -> gnt=0010 next cycle; ena=0 mid-pulse -> pulse completes.
REQ-035 With PWE_SCHED_FIXED_PRIO_EN, req=1011 held -> req[0] wins every round, req[1], req[3] starve.
